// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
//   Pulls words from an upstream synchronous FIFO that has one cycle of read
//   latency. It presents them as a registered valid/ready stream through a
//   3-entry circular skid buffer. Reads are issued only while the buffered
//   words plus the word in flight leave room in the buffer. Because of this,
//   backpressure on the stream side never overflows the buffer.
//
// Ports
//   clock        system clock, all state on the rising edge
//   reset        asynchronous, active-high reset
//   fifo_rdData  upstream read data, valid the cycle after fifo_rd_en
//   fifo_empty   upstream FIFO empty flag
//   fifo_rd_en   upstream read enable (combinational)
//   flush        synchronous discard of buffered and in-flight words
//   m_data       stream data (registered head entry)
//   m_valid      stream valid (registered, equals buf_cnt != 0)
//   m_ready      downstream accept
//   buf_cnt      number of buffered words, 0..3
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] fifo_rdData,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [1:0]            buf_cnt
);

  localparam int SKID_DEPTH = 3;

  logic [DATA_WIDTH-1:0] mem_reg [SKID_DEPTH];
  logic [1:0]            head_reg, tail_reg, cnt_reg;
  logic                  inflight_reg;
  logic                  m_valid_reg;
  logic [DATA_WIDTH-1:0] m_data_reg;

  logic                  push, pop;
  logic [1:0]            head_next, tail_next, cnt_next;
  logic [DATA_WIDTH-1:0] head_data_next;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // The word in flight is counted as occupied space. Then a read issued now
  // always has a free slot when its data lands next cycle.
  assign fifo_rd_en = !reset && !flush && !fifo_empty &&
                      (({1'b0, cnt_reg} + {2'b00, inflight_reg}) < 3'd3);

  assign push = inflight_reg && !flush;
  assign pop  = m_valid_reg && m_ready;

  always_comb begin
    head_next = pop  ? ptr_inc(head_reg) : head_reg;
    tail_next = push ? ptr_inc(tail_reg) : tail_reg;
    cnt_next  = cnt_reg;
    case ({push, pop})
      2'b10:   cnt_next = cnt_reg + 2'd1;
      2'b01:   cnt_next = cnt_reg - 2'd1;
      default: cnt_next = cnt_reg;
    endcase
    // If the new head slot is the one being written this cycle, take the
    // incoming word directly. The storage is only updated at the edge.
    case (head_next)
      2'd0:    head_data_next = mem_reg[0];
      2'd1:    head_data_next = mem_reg[1];
      default: head_data_next = mem_reg[2];
    endcase
    if (push && (head_next == tail_reg))
      head_data_next = fifo_rdData;
  end

  // Buffer storage holds no reset state. Pointers and count decide which
  // entries are meaningful.
  generate
    for (genvar gi = 0; gi < SKID_DEPTH; gi++) begin : g_entry
      always_ff @(posedge clock) begin
        if (push && (tail_reg == 2'(gi)))
          mem_reg[gi] <= fifo_rdData;
      end
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_reg     <= 2'd0;
      tail_reg     <= 2'd0;
      cnt_reg      <= 2'd0;
      inflight_reg <= 1'b0;
      m_valid_reg  <= 1'b0;
      m_data_reg   <= '0;
    end else if (flush) begin
      // Flush overrides any pop that happens in the same cycle. The popped
      // word was already taken downstream.
      head_reg     <= 2'd0;
      tail_reg     <= 2'd0;
      cnt_reg      <= 2'd0;
      inflight_reg <= 1'b0;
      m_valid_reg  <= 1'b0;
    end else begin
      head_reg     <= head_next;
      tail_reg     <= tail_next;
      cnt_reg      <= cnt_next;
      inflight_reg <= fifo_rd_en;
      m_valid_reg  <= (cnt_next != 2'd0);
      // Data only moves when a valid word will be presented. While the
      // stream is stalled, head_next is unchanged, so m_data holds its value.
      if (cnt_next != 2'd0)
        m_data_reg <= head_data_next;
    end
  end

  // A push into a full buffer without a matching pop means the read gating
  // above is broken.
  always @(posedge clock) begin
    if (!reset && push && !pop)
      assert (cnt_reg != 2'd3);
  end

  assign m_data  = m_data_reg;
  assign m_valid = m_valid_reg;
  assign buf_cnt = cnt_reg;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader
//   Directed bench for fifo_stream_reader. An upstream FIFO with one cycle of
//   read latency is modelled from a source queue. Every word handed to the
//   DUT is pushed to a scoreboard queue. Each accepted stream word is popped
//   from that queue and compared. Flush and reset empty the scoreboard.
module tb_fifo_stream_reader;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] fifo_rdData = 8'h00;
  logic       fifo_empty = 1'b1;
  logic       fifo_rd_en;
  logic       flush = 1'b0;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [1:0] buf_cnt;

  fifo_stream_reader #(.DATA_WIDTH(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .fifo_rdData (fifo_rdData),
    .fifo_empty  (fifo_empty),
    .fifo_rd_en  (fifo_rd_en),
    .flush       (flush),
    .m_data      (m_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .buf_cnt     (buf_cnt)
  );

  always #5 clock = ~clock;

  logic [7:0] src_q[$];
  logic [7:0] exp_q[$];
  int         n_assert = 0;
  int         n_fail   = 0;
  int         n_deliv  = 0;
  int         rd_cnt   = 0;
  logic       last_rd, last_valid;
  logic [7:0] last_pop;
  logic       hold_pending = 1'b0;
  logic [7:0] held_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) src_q.push_back(base + 8'(i));
    fifo_empty = (src_q.size() == 0);
  endtask

  // One clock period. Inputs are already set at entry (posedge+1). Outputs
  // are checked at the falling edge. The task returns at the next posedge+1.
  task automatic cycle();
    logic       rd, fl, rs;
    logic [7:0] e;
    @(negedge clock);
    if (fifo_empty) chk("rd_en_while_empty", {31'd0, fifo_rd_en}, 32'd0);
    if (flush)      chk("rd_en_during_flush", {31'd0, fifo_rd_en}, 32'd0);
    chk("valid_vs_cnt", {31'd0, m_valid}, {31'd0, (buf_cnt != 2'd0)});
    if (hold_pending) begin
      chk("hold_valid", {31'd0, m_valid}, 32'd1);
      chk("hold_data", {24'd0, m_data}, {24'd0, held_data});
    end
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", {24'd0, m_data}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("data_order", {24'd0, m_data}, {24'd0, e});
      end
      n_deliv++;
      last_pop = m_data;
    end
    hold_pending = m_valid && !m_ready && !flush && !reset;
    held_data    = m_data;
    last_rd      = fifo_rd_en;
    last_valid   = m_valid;
    rd = fifo_rd_en; fl = flush; rs = reset;
    @(posedge clock);
    #1;
    if (fl || rs) exp_q.delete();
    if (rd && src_q.size() != 0) begin
      e = src_q.pop_front();
      fifo_rdData = e;
      exp_q.push_back(e);
      rd_cnt++;
    end else begin
      fifo_rdData = 8'($urandom);
    end
    fifo_empty = (src_q.size() == 0);
  endtask

  task automatic reset_on();
    reset = 1'b1; flush = 1'b0; m_ready = 1'b0;
    src_q.delete(); exp_q.delete();
    hold_pending = 1'b0; fifo_empty = 1'b1;
    cycle();
  endtask

  initial begin : stim
    int exp_rd[6];
    int exp_v[6];
    int first_rd, first_v, d0;

    // ---- Scenario 1: three-word burst, checks latency and reset state ----
    #1;
    reset_on();
    load(3, 8'h11);
    src_q.delete(); src_q.push_back(8'h11); src_q.push_back(8'h22); src_q.push_back(8'h33);
    fifo_empty = 1'b0;
    #1;
    chk("reset_valid", {31'd0, m_valid}, 32'd0);
    chk("reset_cnt",   {30'd0, buf_cnt}, 32'd0);
    chk("reset_data",  {24'd0, m_data},  32'd0);
    chk("reset_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    cycle();
    reset = 1'b0; m_ready = 1'b1;
    exp_rd = '{1, 1, 1, 0, 0, 0};
    exp_v  = '{0, 0, 1, 1, 1, 0};
    for (int c = 0; c < 6; c++) begin
      cycle();
      chk($sformatf("s1_rd_en_c%0d", c), {31'd0, last_rd}, 32'(exp_rd[c]));
      chk($sformatf("s1_valid_c%0d", c), {31'd0, last_valid}, 32'(exp_v[c]));
    end
    chk("s1_delivered", 32'(n_deliv), 32'd3);

    // ---- Scenario 2: ten words under backpressure, then release ----
    reset_on();
    load(10, 8'hA0);
    reset = 1'b0; m_ready = 1'b0; rd_cnt = 0;
    for (int c = 0; c < 6; c++) cycle();
    chk("s2_reads_issued", 32'(rd_cnt), 32'd3);
    chk("s2_buf_full", {30'd0, buf_cnt}, 32'd3);
    chk("s2_rd_en_off", {31'd0, fifo_rd_en}, 32'd0);
    chk("s2_head_data", {24'd0, m_data}, 32'h0000_00A0);
    m_ready = 1'b1; d0 = n_deliv;
    for (int c = 0; c < 10; c++) begin
      cycle();
      chk($sformatf("s2_no_gap_c%0d", c), {31'd0, last_valid}, 32'd1);
    end
    chk("s2_delivered", 32'(n_deliv - d0), 32'd10);
    chk("s2_last_word", {24'd0, last_pop}, 32'h0000_00A9);

    // ---- Scenario 3: empty FIFO, random m_ready ----
    reset_on();
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      m_ready = 1'($urandom_range(0, 1));
      cycle();
      chk("s3_no_read", {31'd0, last_rd}, 32'd0);
      chk("s3_no_valid", {31'd0, last_valid}, 32'd0);
    end

    // ---- Scenario 4: 64-word stream with m_ready toggling ----
    reset_on();
    load(64, 8'h00);
    reset = 1'b0; d0 = n_deliv;
    for (int c = 0; c < 400 && (n_deliv - d0) < 64; c++) begin
      m_ready = ~c[0];
      cycle();
    end
    chk("s4_delivered", 32'(n_deliv - d0), 32'd64);
    chk("s4_last_word", {24'd0, last_pop}, 32'h0000_003F);

    // ---- Scenario 5: flush with two buffered words and one in flight ----
    reset_on();
    load(8, 8'hC0);
    reset = 1'b0; m_ready = 1'b0;
    for (int c = 0; c < 3; c++) cycle();
    flush = 1'b1;
    #1;
    chk("s5_pre_cnt", {30'd0, buf_cnt}, 32'd2);
    cycle();
    flush = 1'b0;
    #1;
    chk("s5_post_valid", {31'd0, m_valid}, 32'd0);
    chk("s5_post_cnt", {30'd0, buf_cnt}, 32'd0);
    m_ready = 1'b1; d0 = n_deliv;
    for (int c = 0; c < 10 && n_deliv == d0; c++) cycle();
    chk("s5_first_after_flush", {24'd0, last_pop}, 32'h0000_00C3);

    // ---- Scenario 6: asynchronous reset pulse mid-stream ----
    reset_on();
    load(20, 8'h40);
    reset = 1'b0; m_ready = 1'b1;
    for (int c = 0; c < 5; c++) cycle();
    #2;
    chk("s6_pre_valid", {31'd0, m_valid}, 32'd1);
    reset = 1'b1;
    #1;
    chk("s6_async_valid", {31'd0, m_valid}, 32'd0);
    chk("s6_async_cnt",   {30'd0, buf_cnt}, 32'd0);
    chk("s6_async_data",  {24'd0, m_data},  32'd0);
    chk("s6_async_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    exp_q.delete(); hold_pending = 1'b0;
    cycle();
    reset = 1'b0;
    first_rd = -1; first_v = -1;
    for (int c = 0; c < 10; c++) begin
      cycle();
      if (first_rd < 0 && last_rd)    first_rd = c;
      if (first_v  < 0 && last_valid) first_v  = c;
    end
    chk("s6_first_rd_cycle", 32'(first_rd), 32'd0);
    chk("s6_latency", 32'(first_v - first_rd), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
